// File: rtl/axi_rd_arbiter.sv
// Read-channel controller for a 2-master / 2-slave AXI3 interconnect.
// Round-robin AR arbitration, address decode to S0/S1/default slave,
// grant held until the last R beat. Unmapped reads get DECERR internally.
module axi_rd_arbiter #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S1_BASE = 32'h0001_0000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [3:0]  ARID_M0,
  input  logic [3:0]  ARID_M1,
  input  logic [31:0] ARADDR_M0,
  input  logic [31:0] ARADDR_M1,
  input  logic [3:0]  ARLEN_M0,
  input  logic [3:0]  ARLEN_M1,
  input  logic [2:0]  ARSIZE_M0,
  input  logic [2:0]  ARSIZE_M1,
  input  logic [1:0]  ARBURST_M0,
  input  logic [1:0]  ARBURST_M1,
  input  logic        ARVALID_M0,
  input  logic        ARVALID_M1,
  output logic        ARREADY_M0,
  output logic        ARREADY_M1,
  output logic [3:0]  RID_M0,
  output logic [3:0]  RID_M1,
  output logic [31:0] RDATA_M0,
  output logic [31:0] RDATA_M1,
  output logic [1:0]  RRESP_M0,
  output logic [1:0]  RRESP_M1,
  output logic        RLAST_M0,
  output logic        RLAST_M1,
  output logic        RVALID_M0,
  output logic        RVALID_M1,
  input  logic        RREADY_M0,
  input  logic        RREADY_M1,
  output logic [7:0]  ARID_S0,
  output logic [7:0]  ARID_S1,
  output logic [31:0] ARADDR_S0,
  output logic [31:0] ARADDR_S1,
  output logic [3:0]  ARLEN_S0,
  output logic [3:0]  ARLEN_S1,
  output logic [2:0]  ARSIZE_S0,
  output logic [2:0]  ARSIZE_S1,
  output logic [1:0]  ARBURST_S0,
  output logic [1:0]  ARBURST_S1,
  output logic        ARVALID_S0,
  output logic        ARVALID_S1,
  input  logic        ARREADY_S0,
  input  logic        ARREADY_S1,
  input  logic [7:0]  RID_S0,
  input  logic [7:0]  RID_S1,
  input  logic [31:0] RDATA_S0,
  input  logic [31:0] RDATA_S1,
  input  logic [1:0]  RRESP_S0,
  input  logic [1:0]  RRESP_S1,
  input  logic        RLAST_S0,
  input  logic        RLAST_S1,
  input  logic        RVALID_S0,
  input  logic        RVALID_S1,
  output logic        RREADY_S0,
  output logic        RREADY_S1,
  output logic        busy
);

  // state | meaning
  // IDLE  | no transaction, arbitrating AR requests
  // ADDR  | AR of granted master forwarded to target (or accepted for DEF)
  // DATA  | R beats routed from target slave to granted master
  // ERR   | default slave returning DECERR beats
  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

  localparam logic [1:0] TGT_S0  = 2'd0;
  localparam logic [1:0] TGT_S1  = 2'd1;
  localparam logic [1:0] TGT_DEF = 2'd2;

  state_t     state_q, state_d;
  logic       gnt_q, gnt_d;
  logic [1:0] tgt_q, tgt_d;
  logic       rr_last_q, rr_last_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  logic [3:0] err_id_q, err_id_d;

  // Master/slave signals gathered into arrays so the muxes index by gnt/tgt.
  logic [3:0]  arid_m [2];
  logic [31:0] araddr_m [2];
  logic [3:0]  arlen_m [2];
  logic [2:0]  arsize_m [2];
  logic [1:0]  arburst_m [2];
  logic [1:0]  arvalid_m, rready_m, arready_s, rvalid_s, rlast_s;
  logic [3:0]  rid_s [2];
  logic [31:0] rdata_s [2];
  logic [1:0]  rresp_s [2];

  assign arid_m    = '{ARID_M0, ARID_M1};
  assign araddr_m  = '{ARADDR_M0, ARADDR_M1};
  assign arlen_m   = '{ARLEN_M0, ARLEN_M1};
  assign arsize_m  = '{ARSIZE_M0, ARSIZE_M1};
  assign arburst_m = '{ARBURST_M0, ARBURST_M1};
  assign arvalid_m = {ARVALID_M1, ARVALID_M0};
  assign rready_m  = {RREADY_M1, RREADY_M0};
  assign arready_s = {ARREADY_S1, ARREADY_S0};
  assign rvalid_s  = {RVALID_S1, RVALID_S0};
  assign rlast_s   = {RLAST_S1, RLAST_S0};
  assign rid_s     = '{RID_S0[3:0], RID_S1[3:0]};
  assign rdata_s   = '{RDATA_S0, RDATA_S1};
  assign rresp_s   = '{RRESP_S0, RRESP_S1};

  // The master index travels in RID_S[7:4]; routing uses the grant instead.
  logic unused_rid_hi;
  assign unused_rid_hi = ^{RID_S0[7:4], RID_S1[7:4]};

  function automatic logic [1:0] decode(input logic [31:0] addr);
    if (addr[31:16] == S0_BASE[31:16])      return TGT_S0;
    else if (addr[31:16] == S1_BASE[31:16]) return TGT_S1;
    else                                    return TGT_DEF;
  endfunction

  // On a tie the master that was not served last wins.
  logic win;
  assign win = (arvalid_m[0] & arvalid_m[1]) ? ~rr_last_q : arvalid_m[1];

  // State and context registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      tgt_q     <= TGT_S0;
      rr_last_q <= 1'b1;
      err_cnt_q <= 4'd0;
      err_id_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      tgt_q     <= tgt_d;
      rr_last_q <= rr_last_d;
      err_cnt_q <= err_cnt_d;
      err_id_q  <= err_id_d;
    end
  end

  // Next-state and context update.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    tgt_d     = tgt_q;
    rr_last_d = rr_last_q;
    err_cnt_d = err_cnt_q;
    err_id_d  = err_id_q;
    case (state_q)
      IDLE: if (|arvalid_m) begin
        gnt_d   = win;
        tgt_d   = decode(araddr_m[win]);
        state_d = ADDR;
      end
      ADDR: begin
        if (!arvalid_m[gnt_q]) begin
          state_d = IDLE;
        end else if (tgt_q == TGT_DEF) begin
          err_cnt_d = arlen_m[gnt_q];
          err_id_d  = arid_m[gnt_q];
          state_d   = ERR;
        end else if (arready_s[tgt_q[0]]) begin
          state_d = DATA;
        end
      end
      DATA: if (rvalid_s[tgt_q[0]] & rready_m[gnt_q] & rlast_s[tgt_q[0]]) begin
        rr_last_d = gnt_q;
        state_d   = IDLE;
      end
      ERR: if (rready_m[gnt_q]) begin
        if (err_cnt_q == 4'd0) begin
          rr_last_d = gnt_q;
          state_d   = IDLE;
        end else begin
          err_cnt_d = err_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [1:0]  arready_mo, rvalid_mo, rlast_mo, arvalid_so, rready_so;
  logic [3:0]  rid_mo [2];
  logic [31:0] rdata_mo [2];
  logic [1:0]  rresp_mo [2];
  logic [7:0]  arid_so [2];
  logic [31:0] araddr_so [2];
  logic [3:0]  arlen_so [2];
  logic [2:0]  arsize_so [2];
  logic [1:0]  arburst_so [2];

  // Output routing: only the granted master and target slave see anything.
  always_comb begin
    arready_mo = '0;
    rvalid_mo  = '0;
    rlast_mo   = '0;
    arvalid_so = '0;
    rready_so  = '0;
    rid_mo     = '{default: '0};
    rdata_mo   = '{default: '0};
    rresp_mo   = '{default: '0};
    arid_so    = '{default: '0};
    araddr_so  = '{default: '0};
    arlen_so   = '{default: '0};
    arsize_so  = '{default: '0};
    arburst_so = '{default: '0};
    case (state_q)
      ADDR: begin
        if (tgt_q == TGT_DEF) begin
          arready_mo[gnt_q] = 1'b1;
        end else begin
          arvalid_so[tgt_q[0]] = arvalid_m[gnt_q];
          arid_so[tgt_q[0]]    = {3'b000, gnt_q, arid_m[gnt_q]};
          araddr_so[tgt_q[0]]  = araddr_m[gnt_q];
          arlen_so[tgt_q[0]]   = arlen_m[gnt_q];
          arsize_so[tgt_q[0]]  = arsize_m[gnt_q];
          arburst_so[tgt_q[0]] = arburst_m[gnt_q];
          arready_mo[gnt_q]    = arready_s[tgt_q[0]];
        end
      end
      DATA: begin
        rid_mo[gnt_q]        = rid_s[tgt_q[0]];
        rdata_mo[gnt_q]      = rdata_s[tgt_q[0]];
        rresp_mo[gnt_q]      = rresp_s[tgt_q[0]];
        rlast_mo[gnt_q]      = rlast_s[tgt_q[0]];
        rvalid_mo[gnt_q]     = rvalid_s[tgt_q[0]];
        rready_so[tgt_q[0]]  = rready_m[gnt_q];
      end
      ERR: begin
        rvalid_mo[gnt_q] = 1'b1;
        rresp_mo[gnt_q]  = 2'b11;
        rid_mo[gnt_q]    = err_id_q;
        rlast_mo[gnt_q]  = (err_cnt_q == 4'd0);
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);

  assign ARREADY_M0 = arready_mo[0];
  assign ARREADY_M1 = arready_mo[1];
  assign RVALID_M0  = rvalid_mo[0];
  assign RVALID_M1  = rvalid_mo[1];
  assign RLAST_M0   = rlast_mo[0];
  assign RLAST_M1   = rlast_mo[1];
  assign RID_M0     = rid_mo[0];
  assign RID_M1     = rid_mo[1];
  assign RDATA_M0   = rdata_mo[0];
  assign RDATA_M1   = rdata_mo[1];
  assign RRESP_M0   = rresp_mo[0];
  assign RRESP_M1   = rresp_mo[1];
  assign ARVALID_S0 = arvalid_so[0];
  assign ARVALID_S1 = arvalid_so[1];
  assign RREADY_S0  = rready_so[0];
  assign RREADY_S1  = rready_so[1];
  assign ARID_S0    = arid_so[0];
  assign ARID_S1    = arid_so[1];
  assign ARADDR_S0  = araddr_so[0];
  assign ARADDR_S1  = araddr_so[1];
  assign ARLEN_S0   = arlen_so[0];
  assign ARLEN_S1   = arlen_so[1];
  assign ARSIZE_S0  = arsize_so[0];
  assign ARSIZE_S1  = arsize_so[1];
  assign ARBURST_S0 = arburst_so[0];
  assign ARBURST_S1 = arburst_so[1];

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: the bench plays both masters and both slaves.
// Expected grants/targets come from a transaction-level model (pending
// requests, last-served master, 64 KiB address windows).
module tb_axi_rd_arbiter;

  logic ACLK, ARESET;

  logic [3:0]  arid_m [2];
  logic [31:0] araddr_m [2];
  logic [3:0]  arlen_m [2];
  logic [2:0]  arsize_m [2];
  logic [1:0]  arburst_m [2];
  logic [1:0]  arvalid_m, rready_m;
  wire  [1:0]  arready_m, rlast_m, rvalid_m;
  wire  [3:0]  rid_m [2];
  wire  [31:0] rdata_m [2];
  wire  [1:0]  rresp_m [2];

  wire  [7:0]  arid_s [2];
  wire  [31:0] araddr_s [2];
  wire  [3:0]  arlen_s [2];
  wire  [2:0]  arsize_s [2];
  wire  [1:0]  arburst_s [2];
  wire  [1:0]  arvalid_s, rready_s;
  logic [1:0]  arready_s, rlast_s, rvalid_s;
  logic [7:0]  rid_s [2];
  logic [31:0] rdata_s [2];
  logic [1:0]  rresp_s [2];
  wire         busy;

  axi_rd_arbiter dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARID_M0(arid_m[0]), .ARID_M1(arid_m[1]),
    .ARADDR_M0(araddr_m[0]), .ARADDR_M1(araddr_m[1]),
    .ARLEN_M0(arlen_m[0]), .ARLEN_M1(arlen_m[1]),
    .ARSIZE_M0(arsize_m[0]), .ARSIZE_M1(arsize_m[1]),
    .ARBURST_M0(arburst_m[0]), .ARBURST_M1(arburst_m[1]),
    .ARVALID_M0(arvalid_m[0]), .ARVALID_M1(arvalid_m[1]),
    .ARREADY_M0(arready_m[0]), .ARREADY_M1(arready_m[1]),
    .RID_M0(rid_m[0]), .RID_M1(rid_m[1]),
    .RDATA_M0(rdata_m[0]), .RDATA_M1(rdata_m[1]),
    .RRESP_M0(rresp_m[0]), .RRESP_M1(rresp_m[1]),
    .RLAST_M0(rlast_m[0]), .RLAST_M1(rlast_m[1]),
    .RVALID_M0(rvalid_m[0]), .RVALID_M1(rvalid_m[1]),
    .RREADY_M0(rready_m[0]), .RREADY_M1(rready_m[1]),
    .ARID_S0(arid_s[0]), .ARID_S1(arid_s[1]),
    .ARADDR_S0(araddr_s[0]), .ARADDR_S1(araddr_s[1]),
    .ARLEN_S0(arlen_s[0]), .ARLEN_S1(arlen_s[1]),
    .ARSIZE_S0(arsize_s[0]), .ARSIZE_S1(arsize_s[1]),
    .ARBURST_S0(arburst_s[0]), .ARBURST_S1(arburst_s[1]),
    .ARVALID_S0(arvalid_s[0]), .ARVALID_S1(arvalid_s[1]),
    .ARREADY_S0(arready_s[0]), .ARREADY_S1(arready_s[1]),
    .RID_S0(rid_s[0]), .RID_S1(rid_s[1]),
    .RDATA_S0(rdata_s[0]), .RDATA_S1(rdata_s[1]),
    .RRESP_S0(rresp_s[0]), .RRESP_S1(rresp_s[1]),
    .RLAST_S0(rlast_s[0]), .RLAST_S1(rlast_s[1]),
    .RVALID_S0(rvalid_s[0]), .RVALID_S1(rvalid_s[1]),
    .RREADY_S0(rready_s[0]), .RREADY_S1(rready_s[1]),
    .busy(busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_fail = 0;

  // Transaction-level model state
  bit         pend_v [2];
  logic [3:0] pend_id [2];
  logic [31:0] pend_addr [2];
  logic [3:0] pend_len [2];
  logic [2:0] pend_size [2];
  logic [1:0] pend_burst [2];
  int         rr_last_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_winner();
    if (pend_v[0] && !pend_v[1]) return 0;
    if (pend_v[1] && !pend_v[0]) return 1;
    return (rr_last_m == 1) ? 0 : 1;
  endfunction

  function automatic int exp_target(input logic [31:0] addr);
    if (addr / 32'h0001_0000 == 0) return 0;
    if (addr / 32'h0001_0000 == 1) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [15:0] hi, lo;
    lo = 16'($urandom);
    case ($urandom_range(0, 2))
      0: hi = 16'h0000;
      1: hi = 16'h0001;
      default: hi = 16'($urandom_range(2, 16'hFFFF));
    endcase
    return {hi, lo};
  endfunction

  task automatic set_req(input int m, input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len);
    pend_v[m] = 1'b1;
    pend_id[m] = id;
    pend_addr[m] = addr;
    pend_len[m] = len;
    pend_size[m] = 3'($urandom);
    pend_burst[m] = 2'($urandom);
    arid_m[m] = id;
    araddr_m[m] = addr;
    arlen_m[m] = len;
    arsize_m[m] = pend_size[m];
    arburst_m[m] = pend_burst[m];
    arvalid_m[m] = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_arready_m"}, arready_m, 0);
    chk({tag, "_rvalid_m"}, rvalid_m, 0);
    chk({tag, "_rlast_m"}, rlast_m, 0);
    chk({tag, "_arvalid_s"}, arvalid_s, 0);
    chk({tag, "_rready_s"}, rready_s, 0);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_rid_m"}, rid_m[i], 0);
      chk({tag, "_rdata_m"}, rdata_m[i], 0);
      chk({tag, "_rresp_m"}, rresp_m[i], 0);
      chk({tag, "_arid_s"}, arid_s[i], 0);
      chk({tag, "_araddr_s"}, araddr_s[i], 0);
      chk({tag, "_arlen_s"}, {arlen_s[i], arsize_s[i], arburst_s[i]}, 0);
    end
  endtask

  // Serve one transaction. Entered between negedge and posedge with the DUT
  // in IDLE and the pending requests already driven; returns just after the
  // negedge of the bubble cycle.
  task automatic serve_one();
    int w, t, b, cyc, len;
    bit hs, rv, rr, ev, el;
    logic [31:0] ed;
    logic [1:0] er;
    logic [3:0] eid;
    w = exp_winner();
    t = exp_target(pend_addr[w]);
    len = int'(pend_len[w]);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_arready_m", arready_m, 0);
    chk("idle_arvalid_s", arvalid_s, 0);
    @(posedge ACLK);
    hs = 0;
    cyc = 0;
    while (!hs && cyc < 50) begin
      @(negedge ACLK);
      arready_s = 2'($urandom);
      if (t != 2) arready_s[t] = ($urandom_range(0, 2) == 0) || (cyc >= 3);
      #1;
      chk("addr_busy", busy, 1);
      chk("addr_loser_arready", arready_m[1-w], 0);
      if (t == 2) begin
        chk("dec_arready", arready_m[w], 1);
        chk("dec_arvalid_s", arvalid_s, 0);
        hs = 1;
      end else begin
        chk("addr_arvalid_tgt", arvalid_s[t], 1);
        chk("addr_arvalid_other", arvalid_s[1-t], 0);
        chk("addr_arid", arid_s[t], {4'(w), pend_id[w]});
        chk("addr_araddr", araddr_s[t], pend_addr[w]);
        chk("addr_arlen", arlen_s[t], pend_len[w]);
        chk("addr_arsize", arsize_s[t], pend_size[w]);
        chk("addr_arburst", arburst_s[t], pend_burst[w]);
        chk("addr_arready_m", arready_m[w], arready_s[t]);
        hs = arready_s[t];
      end
      cyc++;
      @(posedge ACLK);
    end
    if (!hs) chk("addr_timeout", 32'(hs), 1);
    pend_v[w] = 1'b0;
    b = 0;
    cyc = 0;
    while (b <= len && cyc < 300) begin
      @(negedge ACLK);
      arvalid_m[w] = 1'b0;
      arready_s = 2'b00;
      rvalid_s = 2'($urandom);
      rlast_s = 2'($urandom);
      for (int s = 0; s < 2; s++) begin
        rdata_s[s] = $urandom;
        rid_s[s] = 8'($urandom);
        rresp_s[s] = 2'($urandom);
      end
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      rready_m = 2'($urandom);
      rready_m[w] = rr;
      if (t != 2) begin
        rvalid_s[t] = rv;
        rlast_s[t] = (b == len);
        ev = rv; ed = rdata_s[t]; er = rresp_s[t]; eid = rid_s[t][3:0]; el = (b == len);
      end else begin
        ev = 1; ed = 0; er = 2'b11; eid = pend_id[w]; el = (b == len);
      end
      #1;
      chk("data_rvalid", rvalid_m[w], ev);
      chk("data_rdata", rdata_m[w], ed);
      chk("data_rresp", rresp_m[w], er);
      chk("data_rid", rid_m[w], eid);
      chk("data_rlast", rlast_m[w], el);
      chk("data_loser_r", {rvalid_m[1-w], rlast_m[1-w], rdata_m[1-w]}, 0);
      if (t != 2) begin
        chk("data_rready_tgt", rready_s[t], rr);
        chk("data_rready_other", rready_s[1-t], 0);
      end else begin
        chk("err_rready_s", rready_s, 0);
      end
      chk("data_arready_m", arready_m, 0);
      chk("data_arvalid_s", arvalid_s, 0);
      if (ev && rr) b++;
      cyc++;
      @(posedge ACLK);
    end
    if (b <= len) chk("data_timeout", b, len + 1);
    rr_last_m = w;
    @(negedge ACLK);
    rvalid_s = 2'b00;
    rlast_s = 2'b00;
    rready_m = 2'b00;
    #1;
    chk("bubble_busy", busy, 0);
    chk("bubble_arready_m", arready_m, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    arvalid_m = 2'b00; rready_m = 2'b00;
    arready_s = 2'b00; rvalid_s = 2'b00; rlast_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      arid_m[i] = '0; araddr_m[i] = '0; arlen_m[i] = '0; arsize_m[i] = '0;
      arburst_m[i] = '0; rid_s[i] = '0; rdata_s[i] = '0; rresp_s[i] = '0;
      pend_v[i] = 1'b0;
    end
    rr_last_m = 1;
    ARESET = 1'b0;
    #1 ARESET = 1'b1;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;

    // Tie on S1 right after reset: M0 first, then M1.
    set_req(0, 4'h2, 32'h0001_0000, 4'd1);
    set_req(1, 4'h7, 32'h0001_0000, 4'd2);
    serve_one();
    serve_one();

    // M0 alone, S0, 4 beats.
    set_req(0, 4'hA, 32'h0000_0010, 4'd3);
    serve_one();

    // Unmapped address from M1: DECERR, 3 beats, ID 5.
    set_req(1, 4'h5, 32'h0002_0000, 4'd2);
    serve_one();

    // ARLEN=15 DECERR: 16 beats.
    set_req(0, 4'hC, 32'h8000_0000, 4'd15);
    serve_one();

    // Back-to-back from both masters, 4 transactions.
    set_req(0, 4'h1, 32'h0000_0100, 4'd1);
    set_req(1, 4'h9, 32'h0001_0200, 4'd0);
    for (int k = 0; k < 4; k++) begin
      m = exp_winner();
      serve_one();
      if (k < 2) set_req(m, 4'($urandom), rand_addr(), 4'($urandom_range(0, 4)));
    end
    while (pend_v[0] || pend_v[1]) serve_one();

    // Randomized traffic.
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 2; i++)
        if (!pend_v[i] && $urandom_range(0, 1) == 1)
          set_req(i, 4'($urandom), rand_addr(), 4'($urandom_range(0, 15)));
      if (!pend_v[0] && !pend_v[1])
        set_req($urandom_range(0, 1), 4'($urandom), rand_addr(), 4'($urandom_range(0, 7)));
      serve_one();
    end
    while (pend_v[0] || pend_v[1]) serve_one();

    // Withdrawn request in ADDR: back to IDLE, no round-robin update.
    arready_s = 2'b00;
    set_req(1, 4'h4, 32'h0000_0100, 4'd0);
    @(posedge ACLK);
    @(negedge ACLK);
    arvalid_m[1] = 1'b0;
    pend_v[1] = 1'b0;
    #1;
    chk("wd_busy", busy, 1);
    chk("wd_arvalid_s", arvalid_s, 0);
    @(negedge ACLK);
    #1 chk("wd_idle", busy, 0);
    set_req(0, 4'h6, 32'h0001_0040, 4'd1);
    set_req(1, 4'h8, 32'h0000_0040, 4'd1);
    serve_one();
    serve_one();

    // RREADY stall in DATA, then reset mid-burst.
    set_req(0, 4'h3, 32'h0000_0040, 4'd3);
    @(posedge ACLK);
    @(negedge ACLK);
    arready_s[0] = 1'b1;
    #1 chk("stall_arvalid_s0", arvalid_s[0], 1);
    @(posedge ACLK);
    @(negedge ACLK);
    arready_s = 2'b00;
    arvalid_m[0] = 1'b0;
    pend_v[0] = 1'b0;
    rvalid_s[0] = 1'b1;
    rdata_s[0] = 32'hDEAD_BEEF;
    rlast_s[0] = 1'b0;
    rready_m[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_rready_s0", rready_s[0], 0);
      chk("stall_rvalid_m0", rvalid_m[0], 1);
      chk("stall_rdata_m0", rdata_m[0], 32'hDEAD_BEEF);
      @(negedge ACLK);
    end
    ARESET = 1'b1;
    #1 chk_all_zero("midreset");
    @(negedge ACLK);
    ARESET = 1'b0;
    rvalid_s = 2'b00;
    rlast_s = 2'b00;
    rr_last_m = 1;
    set_req(0, 4'hE, 32'h0000_0080, 4'd0);
    set_req(1, 4'hF, 32'h0001_0080, 4'd0);
    serve_one();
    serve_one();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Read-channel controller for the 2-master / 2-slave AXI3 interconnect.
- Arbitrates AR requests from M0 and M1 round-robin, decodes the target slave from ARADDR, and routes the AR and R channels between the granted master and its slave.
- Holds the grant for the whole burst, up to the last R beat.
- Unmapped addresses are answered by an internal default slave with DECERR.

Parameters:
- S0_BASE, 32'h0000_0000, base address of slave 0 (64 KiB window, ARADDR[31:16] compare)
- S1_BASE, 32'h0001_0000, base address of slave 1 (64 KiB window)

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- ARID_M0/ARID_M1  in  4  master read IDs
- ARADDR_M0/ARADDR_M1  in  32  master read addresses
- ARLEN_M0/ARLEN_M1  in  4  burst length minus 1
- ARSIZE_M0/ARSIZE_M1  in  3  beat size
- ARBURST_M0/ARBURST_M1  in  2  burst type
- ARVALID_M0/ARVALID_M1  in  1  master AR valid
- ARREADY_M0/ARREADY_M1  out  1  master AR ready
- RID_M0/RID_M1  out  4  returned ID
- RDATA_M0/RDATA_M1  out  32  read data
- RRESP_M0/RRESP_M1  out  2  read response
- RLAST_M0/RLAST_M1  out  1  last beat
- RVALID_M0/RVALID_M1  out  1  R valid to master
- RREADY_M0/RREADY_M1  in  1  R ready from master
- ARID_S0/ARID_S1  out  8  slave ID = {4'(master index), ARID_Mx}
- ARADDR_S0/S1 (32), ARLEN_S0/S1 (4), ARSIZE_S0/S1 (3), ARBURST_S0/S1 (2)  out  request fields to slaves
- ARVALID_S0/ARVALID_S1  out  1  slave AR valid
- ARREADY_S0/ARREADY_S1  in  1  slave AR ready
- RID_S0/RID_S1  in  8  slave R ID
- RDATA_S0/RDATA_S1 (32), RRESP_S0/S1 (2), RLAST_S0/S1 (1), RVALID_S0/S1 (1)  in  slave R channel
- RREADY_S0/RREADY_S1  out  1  R ready to slave
- busy  out  1  high in any state except IDLE

Behaviour:
- Interface: one clock ACLK; reset ARESET is asynchronous and active-high.
- Reset state:
  - FSM=IDLE, gnt=0, tgt=S0, rr_last=1 (M0 wins the first tie), err_cnt=0, err_id=0.
  - All VALID/READY/RLAST/busy outputs are 0; all data/ID/resp outputs are 0.
  - Reset asserted mid-burst forces outputs to reset values immediately, with no completion of the burst.
- FSM states: IDLE, ADDR, DATA, ERR.
- IDLE:
  - If exactly one ARVALID_Mx is high, that master wins.
  - If both are high, the master != rr_last wins.
  - On a win: register gnt; register tgt = S0, S1 or DEF from the winner's ARADDR[31:16] vs S0_BASE/S1_BASE [31:16]; go to ADDR.
  - No outputs are asserted in IDLE.
- ADDR, tgt = S0 or S1:
  - ARVALID_S[tgt]=ARVALID_M[gnt], with fields muxed from master gnt.
  - ARREADY_M[gnt]=ARREADY_S[tgt].
  - On handshake, go to DATA.
- ADDR, tgt = DEF:
  - ARREADY_M[gnt]=1 for exactly one cycle.
  - err_cnt<=ARLEN_M[gnt] and err_id<=ARID_M[gnt]; go to ERR.
- ADDR, withdrawn request: if ARVALID_M[gnt] is low, return to IDLE with no handshake and no rr_last update.
- Latency: ARVALID_Mx rising in IDLE gives ARVALID_Sy on the next cycle.
- DATA:
  - RID_M[gnt]=RID_S[tgt][3:0]; RDATA/RRESP/RLAST/RVALID_M[gnt] = slave values.
  - RREADY_S[tgt]=RREADY_M[gnt].
  - On RVALID&RREADY&RLAST: rr_last<=gnt, go to IDLE.
  - RID_S upper bits are not checked.
- ERR:
  - RVALID_M[gnt]=1, RDATA=0, RRESP=2'b11, RID=err_id, RLAST=(err_cnt==0).
  - Each handshake decrements err_cnt.
  - Handshake with err_cnt==0: rr_last<=gnt, go to IDLE.
- Non-granted master and non-target slave: all VALID/READY outputs are 0 in every state; data outputs are 0.
- Concurrency: at most one outstanding read. After a last beat, FSM returns to IDLE for one cycle before the next grant (1-cycle bubble).
- A new ARVALID arriving during ADDR/DATA/ERR waits and sees ARREADY=0.
- RREADY low stalls indefinitely; there is no timeout.
- Width rule: err_cnt is 4 bits; ARLEN=15 yields 16 beats.

Test Plan:
- M0 only reads 0x0000_0010, ARLEN=3 from S0 -> ARVALID_S0 one cycle later with ARID_S0=8'h0_ID; 4 beats forwarded to M0; after RLAST, busy=0 one cycle later.
- M0 and M1 assert ARVALID in the same cycle, both targeting S1 (0x0001_0000) -> M0 served first; M1 granted only after M0's RLAST handshake; ARID_S1 upper nibble=4'h1 for M1.
- M1 reads 0x0002_0000, ARLEN=2, ID=5 -> ARREADY_M1 pulses once; 3 beats RDATA=0, RRESP=2'b11, RID=5; RLAST on the 3rd beat only.
- Back-to-back requests from both masters, 4 transactions -> grants alternate M0,M1,M0,M1; no transaction to the non-target slave sees any VALID.
- During DATA, RREADY_M0 held low 5 cycles -> RREADY_S0=0 and the beat is held; then ARESET pulsed mid-burst -> all VALID/READY outputs 0 immediately; FSM=IDLE and M0 wins the next tie.
